// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter (LSB first) for the FPGA-to-host line of the
// USB-UART bridge. A byte is accepted from a valid/ready source and
// serialised onto UART_RXD_OUT. Each bit lasts CLKS_PER_BIT clocks.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
//
// Handshake: a transfer happens on a rising edge of CLK100MHZ where
// tx_valid_i && tx_ready_o. tx_ready_o is high only in IDLE. tx_data_i is
// sampled on that edge only. While busy, tx_valid_i and tx_data_i are ignored.
module uart_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8
) (
    input  logic                 CLK100MHZ,
    input  logic                 BTNC,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic                 tx_busy_o,
    output logic                 UART_RXD_OUT
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t                 state_q;
    state_t                 state_d;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   shift_d;
    logic                   line_q;
    logic                   line_d;
    logic                   accept;
    logic                   bit_tick;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q;
`endif

    assign accept   = (state_q == S_IDLE) && tx_valid_i;
    assign bit_tick = (state_q != S_IDLE) && (cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every non-idle state advances on the baud tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid_i) state_d = S_START;
            end
            S_START: begin
                if (bit_tick) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_tick && (idx_q == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_tick) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next shift-register value: load on accept, shift right on each data tick.
    always_comb begin
        shift_d = shift_q;
        if (accept) begin
            shift_d = tx_data_i;
        end else if ((state_q == S_DATA) && bit_tick) begin
            shift_d = shift_q >> 1;
        end
    end

    // Output decode: handshake flags from the current state, and the next
    // line level from the next state so the registered line moves on the
    // same edge as the state/bit change.
    always_comb begin
        tx_ready_o = (state_q == S_IDLE);
        tx_busy_o  = (state_q != S_IDLE);
        line_d     = 1'b1;
        case (state_d)
            S_IDLE:   line_d = 1'b1;
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: line_d = parity_q;
`endif
            S_STOP:   line_d = 1'b1;
            default:  line_d = 1'b1;
        endcase
    end

    // Baud counter: held at 0 in IDLE, wraps to 0 on the tick otherwise.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC || (state_q == S_IDLE) || bit_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Bit index: advances per data bit, cleared when the last data bit ends.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            idx_q <= '0;
        end else if ((state_q == S_DATA) && bit_tick) begin
            if (idx_q == IDX_LAST) begin
                idx_q <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Shift register and registered serial line (idle high, glitch-free).
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            shift_q <= '0;
            line_q  <= 1'b1;
        end else begin
            shift_q <= shift_d;
            line_q  <= line_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the accepted byte, captured once at acceptance.
    always_ff @(posedge CLK100MHZ) begin
        if (BTNC) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^tx_data_i;
        end
    end
`endif

    assign UART_RXD_OUT = line_q;

endmodule
